// File: rtl/neo_stream.sv
// neo_stream: multi-channel streaming Nonlinear Energy Operator with spike detection.
// psi[n] = x[n-1]^2 - x[n]*x[n-2], computed per channel in a two-stage stalling
// pipeline. Each result is compared against a threshold and gated by a
// per-channel refractory counter.
module neo_stream #(
    parameter int N       = 16,
    parameter int C       = 4,
    parameter int REFRACT = 8,
    localparam int CW     = (C > 1) ? $clog2(C) : 1,
    localparam int RW     = ($clog2(REFRACT + 1) > 1) ? $clog2(REFRACT + 1) : 1
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_data,
    input  logic [CW-1:0]         in_ch,
    input  logic [2*N-1:0]        threshold,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*N:0]   out_data,
    output logic [CW-1:0]         out_ch,
    output logic                  out_spike
);

    // Per-channel history, fill count and refractory counter
    logic signed [N-1:0]   h1_r [C];
    logic signed [N-1:0]   h2_r [C];
    logic [1:0]            f_r  [C];
    logic [RW-1:0]         r_r  [C];

    // Stage-1 registers
    logic                  s1_valid_r;
    logic [CW-1:0]         s1_ch_r;
    logic signed [2*N-1:0] s1_a2_r;
    logic signed [2*N-1:0] s1_bc_r;

    // Combinational helpers
    logic                  en_s;
    logic                  accept_s;
    logic                  ch_ok_s;
    logic                  warm_s;
    logic [31:0]           ch_idx_s;
    logic signed [2*N-1:0] h1_x_s;
    logic signed [2*N-1:0] h2_x_s;
    logic signed [2*N-1:0] x_x_s;
    logic signed [2*N-1:0] a2_s;
    logic signed [2*N-1:0] bc_s;
    logic signed [2*N:0]   psi_s;
    logic signed [2*N:0]   thr_s;
    logic [RW-1:0]         r_cur_s;
    logic                  spike_s;

    // The whole pipe moves together; it only freezes when a result is parked at the output
    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s && reset;
    assign accept_s = in_valid && in_ready;

    // Stage-1 operand selection and products from the pre-update history of the addressed channel
    always_comb begin
        ch_idx_s = 32'(in_ch);
        ch_ok_s  = (ch_idx_s < 32'(C));
        h1_x_s   = {(2*N){1'b0}};
        h2_x_s   = {(2*N){1'b0}};
        warm_s   = 1'b0;
        if (ch_ok_s) begin
            h1_x_s = {{N{h1_r[in_ch][N-1]}}, h1_r[in_ch]};
            h2_x_s = {{N{h2_r[in_ch][N-1]}}, h2_r[in_ch]};
            warm_s = (f_r[in_ch] == 2'd2);
        end else begin
            h1_x_s = {(2*N){1'b0}};
            h2_x_s = {(2*N){1'b0}};
            warm_s = 1'b0;
        end
        x_x_s = {{N{in_data[N-1]}}, in_data};
        a2_s  = h1_x_s * h1_x_s;
        bc_s  = x_x_s * h2_x_s;
    end

    // Stage-2 difference, threshold compare and refractory gating
    always_comb begin
        psi_s   = {s1_a2_r[2*N-1], s1_a2_r} - {s1_bc_r[2*N-1], s1_bc_r};
        thr_s   = {1'b0, threshold};
        r_cur_s = {RW{1'b0}};
        if (s1_valid_r) begin
            r_cur_s = r_r[s1_ch_r];
        end else begin
            r_cur_s = {RW{1'b0}};
        end
        spike_s = s1_valid_r && (psi_s > thr_s) && (r_cur_s == {RW{1'b0}});
    end

    // History shift on accept; out-of-range channels leave every channel untouched
    always_ff @(posedge Clk) begin
        if (!reset) begin
            for (int i = 0; i < C; i++) begin
                h1_r[i] <= {N{1'b0}};
                h2_r[i] <= {N{1'b0}};
                f_r[i]  <= 2'd0;
            end
        end else if (accept_s && ch_ok_s) begin
            h2_r[in_ch] <= h1_r[in_ch];
            h1_r[in_ch] <= in_data;
            if (f_r[in_ch] != 2'd2) begin
                f_r[in_ch] <= f_r[in_ch] + 2'd1;
            end
        end
    end

    // Refractory counters: reload on spike, otherwise count down on that channel's own results
    always_ff @(posedge Clk) begin
        if (!reset) begin
            for (int i = 0; i < C; i++) begin
                r_r[i] <= {RW{1'b0}};
            end
        end else if (en_s && s1_valid_r) begin
            if (spike_s) begin
                r_r[s1_ch_r] <= RW'(REFRACT);
            end else if (r_cur_s != {RW{1'b0}}) begin
                r_r[s1_ch_r] <= r_cur_s - RW'(1);
            end
        end
    end

    // Stage 1: register the two products; only warmed-up channels produce a result
    always_ff @(posedge Clk) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_ch_r    <= {CW{1'b0}};
            s1_a2_r    <= {(2*N){1'b0}};
            s1_bc_r    <= {(2*N){1'b0}};
        end else if (en_s) begin
            s1_valid_r <= accept_s && ch_ok_s && warm_s;
            s1_ch_r    <= in_ch;
            s1_a2_r    <= a2_s;
            s1_bc_r    <= bc_s;
        end
    end

    // Stage 2: registered outputs, held stable while the consumer stalls
    always_ff @(posedge Clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= {(2*N+1){1'b0}};
            out_ch    <= {CW{1'b0}};
            out_spike <= 1'b0;
        end else if (en_s) begin
            out_valid <= s1_valid_r;
            out_data  <= psi_s;
            out_ch    <= s1_ch_r;
            out_spike <= spike_s;
        end
    end

endmodule

// File: doc/neo_stream.md
# neo_stream

Streaming, multi-channel Nonlinear Energy Operator with per-channel spike detection. It accepts interleaved samples from C channels over a valid/ready handshake and computes psi[n] = x[n-1]^2 - x[n]*x[n-2] per channel in a 2-stage stalling pipeline. Each result is compared against a programmable threshold, gated by a per-channel refractory counter. It supersedes the single-channel, memory-scanning NEO datapath as the front end of the spike-detection chain.

## Interface
- N, 16: signed sample width.
- C, 4: channel count (C >= 1). CW = max(1, $clog2(C)).
- REFRACT, 8: refractory length, counted in output samples of the same channel (0 disables refractory).
- Clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of Clk.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept this cycle.
- in_data  in  N  signed sample.
- in_ch  in  CW  channel index of in_data.
- threshold  in  2N  unsigned spike threshold, zero-extended to 2N+1 signed; sampled at stage 2.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_data  out  2N+1  signed psi.
- out_ch  out  CW  channel of out_data.
- out_spike  out  1  spike flag qualified by out_valid.

## Operation
- Per channel state: h1 (x[n-1]), h2 (x[n-2]), fill count f in {0,1,2}, refractory counter r (width $clog2(REFRACT+1), min 1).
- Accept = in_valid && in_ready. On accept with in_ch < C: h2 <= h1, h1 <= in_data, f <= min(f+1, 2). Result is produced only if f was already 2 before this sample; otherwise history updates and nothing enters the pipe.
- in_ch >= C (non-power-of-2 C): accepted and silently dropped, no state change.
- Stage 1 registers a2 = h1*h1 and bc = in_data*h2 (signed, 2N bits each), plus channel and valid.
- Stage 2 registers out_data = sign-extended a2 - bc (2N+1 bits, never overflows). It also registers out_ch and out_valid.
- Spike: out_spike = (psi > threshold) && (r[ch] == 0), computed from stage-1 values when loading stage 2.
- Refractory: on load into stage 2 for channel ch, if spike then r[ch] <= REFRACT; else if r[ch] != 0 then r[ch] <= r[ch]-1. Only results of that channel decrement it.
- Back-to-back samples of the same channel are legal. History is updated at accept, so no hazard.

## Timing
- Pipeline enable en = !out_valid || out_ready; in_ready = en && reset. Whole pipe (stage 1, stage 2) advances only when en=1. It holds otherwise, with out_* stable while out_valid && !out_ready.
- Latency: sample accepted in cycle t (f==2) -> out_valid in cycle t+2 when unstalled. Throughput 1 result/cycle.
- Reset (reset==0 at edge):
  - Cleared to 0: out_valid, out_data, out_ch, out_spike, all h1/h2/f/r, stage-1 valid.
  - in_ready is 0 while reset is low and 1 in the first cycle after release.
  - Reset asserted mid-stream discards in-flight results. Refractory and history restart; the first two samples per channel again produce no output.
- Simultaneous accept and output handshake in same cycle: both occur; no bubble.
- threshold may change any cycle; applies to the result loading stage 2 that cycle.

## Test plan
- Warm-up/basic, C=4 N=16: ch0 samples 3,4,5, then 6 -> only two results; ch0 psi=1 (16-15) then psi=1 (25-24), 2 cycles after the 3rd/4th accept.
- Extremes: ch1 -32768,0,32767 -> psi=1073709056; ch2 -32768,32767,-32768 -> psi=-65535; ch3 three of -32768 -> psi=0; no wrap.
- Interleave: round-robin ch0..3 with ch k fed k,k+1,k+2 repeatedly -> each channel's psi matches a per-channel golden model; out_ch follows input order.
- Backpressure: random out_ready (50%), random in_valid -> no loss or duplication; out_* stable while stalled; in_ready == !out_valid || out_ready.
- Refractory, REFRACT=2, threshold=0: ch0 stream yielding psi 5,5,5,5 -> out_spike 1,0,0,1. Interleaved ch1 results do not decrement ch0's counter.
- Reset mid-stream: assert reset with 2 results in flight -> out_valid=0 next cycle, no stale output. After release, ch0 needs 2 fresh samples before its next result; in_ready=0 during reset.
